// File: rtl/gpio_pad_pkg.sv
// Shared encodings for the GPIO pad controller: pad pull codes, interrupt
// trigger types and the per-channel trigger evaluation.
package gpio_pad_pkg;

  localparam logic [1:0] PULL_NONE = 2'b00;
  localparam logic [1:0] PULL_DOWN = 2'b10;
  localparam logic [1:0] PULL_UP   = 2'b11;

  typedef enum logic [1:0] {
    IRQ_RISE  = 2'b00,
    IRQ_FALL  = 2'b01,
    IRQ_BOTH  = 2'b10,
    IRQ_LEVEL = 2'b11
  } irq_type_e;

  // cur is the filtered input this cycle, prev is the same signal one cycle older.
  function automatic logic irq_event(irq_type_e kind, logic cur, logic prev);
    logic hit;
    hit = 1'b0;
    case (kind)
      IRQ_RISE:  hit = cur & ~prev;
      IRQ_FALL:  hit = ~cur & prev;
      IRQ_BOTH:  hit = cur ^ prev;
      IRQ_LEVEL: hit = cur;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-channel input filter. With GPIO_DEBOUNCE_EN defined, a new level is
// accepted only after DEB_CNT consecutive cycles; otherwise a single register.
module gpio_debounce #(
  parameter int DEB_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  output logic filt
);

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Any cycle where sync agrees with filt restarts the count from zero.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = sync;
      else                   cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end
`else
  logic filt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) filt_q <= 1'b0;
    else        filt_q <= sync;
  end

  // DEB_CNT is kept for a uniform instantiation; it shapes nothing in this build.
  if (DEB_CNT < 1) begin : g_deb_cnt_ignored
  end
`endif

  assign filt = filt_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// N-channel GPIO pad controller: registered pad outputs, synchronised and
// filtered inputs, sticky interrupt status. Filter depth set by GPIO_DEBOUNCE_EN.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int DEB_CNT = 4
) (
  input  logic [N_CH-1:0]   out_val,
  input  logic [N_CH-1:0]   oen,
  input  logic [2*N_CH-1:0] pull,
  input  logic [N_CH-1:0]   irq_en,
  input  logic [2*N_CH-1:0] irq_type,
  input  logic [N_CH-1:0]   irq_clr,
  input  logic [N_CH-1:0]   pad_dout,
  input  logic              clk,
  input  logic              rst_n,
  output logic [N_CH-1:0]   PAD_DIN,
  output logic [N_CH-1:0]   PAD_OEN,
  output logic [2*N_CH-1:0] PAD_PULL,
  output logic [N_CH-1:0]   in_val,
  output logic [N_CH-1:0]   irq_status,
  output logic              irq
);

  logic [N_CH-1:0]   din_q, oen_q;
  logic [2*N_CH-1:0] pull_q;
  logic [N_CH-1:0]   sync1_q, sync2_q;
  logic [N_CH-1:0]   filt, filt_dly_q;
  logic [N_CH-1:0]   irq_set;
  logic [N_CH-1:0]   status_q, status_d;
  logic              irq_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q      <= '0;
      oen_q      <= '1;
      pull_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_dly_q <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      din_q      <= out_val;
      oen_q      <= oen;
      pull_q     <= pull;
      sync1_q    <= pad_dout;
      sync2_q    <= sync1_q;
      filt_dly_q <= filt;
      status_q   <= status_d;
      irq_q      <= |status_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    gpio_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .sync  (sync2_q[i]),
      .filt  (filt[i])
    );
  end

  // Driven channels (registered OEN low) never raise status; a set beats a clear.
  always_comb begin
    irq_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      irq_set[i] = irq_en[i] & oen_q[i] &
                   irq_event(irq_type_e'(irq_type[2*i +: 2]), filt[i], filt_dly_q[i]);
    end
    status_d = irq_set | (status_q & ~irq_clr);
  end

  assign PAD_DIN    = din_q;
  assign PAD_OEN    = oen_q;
  assign PAD_PULL   = pull_q;
  assign in_val     = filt;
  assign irq_status = status_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: a window-based input model checked every cycle,
// plus directed scenarios with literal expectations. Follows GPIO_DEBOUNCE_EN.
module tb_gpio_pad_ctrl;

  localparam int N_CH    = 8;
  localparam int DEB_CNT = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT_IN = 2 + DEB_CNT;
`else
  localparam int LAT_IN = 3;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_CH-1:0]     out_val, oen, irq_en, irq_clr, pad_dout;
  logic [2*N_CH-1:0]   pull, irq_type;
  logic [N_CH-1:0]     PAD_DIN, PAD_OEN, in_val, irq_status;
  logic [2*N_CH-1:0]   PAD_PULL;
  logic                irq;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  gpio_pad_ctrl #(.N_CH(N_CH), .DEB_CNT(DEB_CNT)) dut (
    .out_val    (out_val),
    .oen        (oen),
    .pull       (pull),
    .irq_en     (irq_en),
    .irq_type   (irq_type),
    .irq_clr    (irq_clr),
    .pad_dout   (pad_dout),
    .clk        (clk),
    .rst_n      (rst_n),
    .PAD_DIN    (PAD_DIN),
    .PAD_OEN    (PAD_OEN),
    .PAD_PULL   (PAD_PULL),
    .in_val     (in_val),
    .irq_status (irq_status),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: the input is accepted once the last DEB_CNT synchronised samples agree.
  logic [N_CH-1:0]   m_din, m_oen, m_s1, m_sync, m_filt, m_filtd, m_status;
  logic [2*N_CH-1:0] m_pull;
  bit                m_valid = 1'b0;
`ifdef GPIO_DEBOUNCE_EN
  logic [15:0]       m_win [N_CH];
`endif

  always @(posedge clk) begin : model
    logic [N_CH-1:0] seen;
    logic [N_CH-1:0] set_v;
    logic            ev;
    int              ones;
    if (!rst_n) begin
      m_din = '0; m_oen = '1; m_pull = '0;
      m_s1 = '0; m_sync = '0; m_filt = '0; m_filtd = '0; m_status = '0;
`ifdef GPIO_DEBOUNCE_EN
      for (int c = 0; c < N_CH; c++) m_win[c] = '0;
`endif
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        case (irq_type[2*c +: 2])
          2'b00:   ev = m_filt[c] && !m_filtd[c];
          2'b01:   ev = !m_filt[c] && m_filtd[c];
          2'b10:   ev = m_filt[c] != m_filtd[c];
          default: ev = m_filt[c];
        endcase
        set_v[c] = irq_en[c] && m_oen[c] && ev;
      end
      m_status = set_v | (m_status & ~irq_clr);
      m_din = out_val; m_oen = oen; m_pull = pull;
      seen    = m_sync;
      m_filtd = m_filt;
`ifdef GPIO_DEBOUNCE_EN
      for (int c = 0; c < N_CH; c++) begin
        m_win[c] = {m_win[c][14:0], seen[c]};
        ones = 0;
        for (int k = 0; k < DEB_CNT; k++) ones += int'(m_win[c][k]);
        if (ones == DEB_CNT) m_filt[c] = 1'b1;
        else if (ones == 0)  m_filt[c] = 1'b0;
      end
`else
      m_filt = seen;
`endif
      m_sync = m_s1;
      m_s1   = pad_dout;
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_pad_din",  32'(PAD_DIN),    32'(m_din));
      chk("m_pad_oen",  32'(PAD_OEN),    32'(m_oen));
      chk("m_pad_pull", 32'(PAD_PULL),   32'(m_pull));
      chk("m_in_val",   32'(in_val),     32'(m_filt));
      chk("m_status",   32'(irq_status), 32'(m_status));
      chk("m_irq",      32'(irq),        32'(|m_status));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [23:0] glitch;
    rst_n = 1'b0; oen = '0; out_val = '1; pull = '0;
    irq_en = '0; irq_type = '0; irq_clr = '0; pad_dout = '0;
    tick(2);
    chk("rst_oen",    32'(PAD_OEN),    32'hFF);
    chk("rst_din",    32'(PAD_DIN),    32'h00);
    chk("rst_in_val", 32'(in_val),     32'h00);
    chk("rst_status", 32'(irq_status), 32'h00);
    chk("rst_irq",    32'(irq),        32'h0);
    rst_n = 1'b1;
    tick(1);
    chk("rel_oen", 32'(PAD_OEN), 32'h00);
    chk("rel_din", 32'(PAD_DIN), 32'hFF);

    oen = '1; out_val = '0; pull = 16'hE1F8;
    tick(1);
    chk("pull_reg", 32'(PAD_PULL), 32'hE1F8);
    chk("oen_in",   32'(PAD_OEN),  32'hFF);
    irq_en = 8'h01; irq_type = '0;
    tick(3);

    // ch0 rising edge, held
    pad_dout[0] = 1'b1;
    tick(LAT_IN - 1);
    chk("deb_early", 32'(in_val[0]), 32'h0);
    tick(1);
    chk("deb_in_val", 32'(in_val[0]),     32'h1);
    chk("deb_pre_st", 32'(irq_status[0]), 32'h0);
    tick(1);
    chk("deb_status", 32'(irq_status[0]), 32'h1);
    chk("deb_irq",    32'(irq),           32'h1);

    irq_en = 8'h03;
`ifdef GPIO_DEBOUNCE_EN
    glitch = 24'b000111000111000111000111;
    for (int i = 0; i < 24; i++) begin
      pad_dout[1] = glitch[i];
      tick(1);
      chk("glitch_in_val", 32'(in_val[1]), 32'h0);
    end
    pad_dout[1] = 1'b0;
    tick(LAT_IN + 2);
    chk("glitch_in_val_end", 32'(in_val[1]),     32'h0);
    chk("glitch_status",     32'(irq_status[1]), 32'h0);
`else
    glitch = 24'h000001;
    pad_dout[1] = glitch[0];
    tick(1);
    pad_dout[1] = 1'b0;
    tick(1);
    chk("pulse_early",  32'(in_val[1]),     32'h0);
    tick(1);
    chk("pulse_in_val", 32'(in_val[1]),     32'h1);
    tick(1);
    chk("pulse_fall",   32'(in_val[1]),     32'h0);
    chk("pulse_status", 32'(irq_status[1]), 32'h1);
`endif

    // clear race on ch0: status already set, new rise coincides with a clear
    pad_dout[0] = 1'b0;
    tick(LAT_IN + 2);
    chk("race_low_in",  32'(in_val[0]),     32'h0);
    chk("race_pre_st",  32'(irq_status[0]), 32'h1);
    pad_dout[0] = 1'b1;
    tick(LAT_IN);
    chk("race_high_in", 32'(in_val[0]), 32'h1);
    irq_clr[0] = 1'b1;
    tick(1);
    irq_clr = '0;
    chk("race_set_wins", 32'(irq_status[0]), 32'h1);
    tick(2);
    irq_clr = '1;
    tick(1);
    irq_clr = '0;
    chk("lone_clear", 32'(irq_status), 32'h00);
    chk("lone_irq",   32'(irq),        32'h0);

    // ch4 rise, ch5 fall, ch6 both, ch7 level
    irq_type = 16'hE400;
    irq_en   = 8'hF1;
    pad_dout[7:4] = 4'hF;
    tick(LAT_IN + 2);
    chk("types_rise", 32'(irq_status[7:4]), 32'hD);
    irq_clr = 8'hF0;
    tick(1);
    irq_clr = '0;
    chk("types_lvl_hold", 32'(irq_status[7:4]), 32'h8);
    pad_dout[7:4] = 4'h0;
    tick(LAT_IN + 2);
    chk("types_fall", 32'(irq_status[7:4]), 32'hE);
    irq_clr = 8'hF0;
    tick(1);
    irq_clr = '0;
    chk("types_clear", 32'(irq_status[7:4]), 32'h0);
    chk("types_irq",   32'(irq),             32'h0);

    // ch2 driven and looped back: input follows, no interrupt
    oen[2] = 1'b0; irq_en[2] = 1'b1; irq_type[5:4] = 2'b10;
    for (int t = 0; t < 4; t++) begin
      out_val[2] = ~out_val[2];
      tick(1);
      pad_dout[2] = out_val[2];
      tick(LAT_IN + 2);
      chk("loop_in_val", 32'(in_val[2]),     32'(out_val[2]));
      chk("loop_status", 32'(irq_status[2]), 32'h0);
    end

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
